// File: rtl/parity_frame_checker_if.sv
// Bus bundle between the serial link front-end and the parity frame checker.
// The front-end (master) drives the bit stream; the checker (slave) returns
// the deserialised word and its status flags.
interface parity_frame_checker_if #(
    parameter int DATA_W = 8
);
    logic              BIT_VALID;
    logic              BIT_IN;
    logic              SOF;
    logic [DATA_W-1:0] DATA_OUT;
    logic              FRAME_VALID;
    logic              PARITY_ERR;
    logic              FRAMING_ERR;
    logic              BUSY;
    logic [7:0]        ERR_CNT;

    modport master (
        output BIT_VALID, BIT_IN, SOF,
        input  DATA_OUT, FRAME_VALID, PARITY_ERR, FRAMING_ERR, BUSY, ERR_CNT
    );

    modport slave (
        input  BIT_VALID, BIT_IN, SOF,
        output DATA_OUT, FRAME_VALID, PARITY_ERR, FRAMING_ERR, BUSY, ERR_CNT
    );
endinterface

// File: rtl/parity_frame_checker.sv
// Receive-side parity frame checker.
// Deserialises DATA_W data bits (LSB first) followed by one parity bit, checks
// the parity, holds the last word, and flags parity and framing errors.
// An SOF seen mid-frame aborts the partial frame and starts a new one with the
// same bit. Every output comes straight from a flop.
module parity_frame_checker #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    parity_frame_checker_if.slave  bus
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    // A frame is in error when the accumulated data parity, the received
    // parity bit and the expected polarity do not XOR to zero.
    function automatic logic parity_mismatch(input logic acc, input logic pbit);
        return acc ^ pbit ^ ODD;
    endfunction

    state_e            state_q,       state_d;
    logic [CW-1:0]     cnt_q,         cnt_d;
    logic              acc_q,         acc_d;
    logic [DATA_W-1:0] shift_q,       shift_d;
    logic [DATA_W-1:0] data_out_q,    data_out_d;
    logic              frame_valid_q, frame_valid_d;
    logic              parity_err_q,  parity_err_d;
    logic              framing_err_q, framing_err_d;
    logic              busy_q,        busy_d;
    logic [7:0]        err_cnt_q,     err_cnt_d;
    logic              err_s;

    // Next-state, datapath and output-flag computation for the frame FSM.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        parity_err_d  = parity_err_q;
        err_cnt_d     = err_cnt_q;
        frame_valid_d = 1'b0;
        framing_err_d = 1'b0;
        err_s         = parity_mismatch(acc_q, bus.BIT_IN);

        if (bus.BIT_VALID && bus.SOF) begin
            // SOF always opens a new frame; outside IDLE it also kills the
            // partial frame, which is reported as a framing error.
            framing_err_d = (state_q != ST_IDLE);
            shift_d       = '0;
            shift_d[0]    = bus.BIT_IN;
            acc_d         = bus.BIT_IN;
            cnt_d         = CW'(1);
            state_d       = (DATA_W == 1) ? ST_PARITY : ST_DATA;
        end else if (bus.BIT_VALID) begin
            case (state_q)
                ST_IDLE: begin
                    // Stray bit with no frame open: dropped silently.
                    state_d = ST_IDLE;
                end
                ST_DATA: begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (cnt_q == CW'(i)) begin
                            shift_d[i] = bus.BIT_IN;
                        end else begin
                            shift_d[i] = shift_q[i];
                        end
                    end
                    acc_d = acc_q ^ bus.BIT_IN;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q + CW'(1) == CW'(DATA_W)) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    data_out_d    = shift_q;
                    parity_err_d  = err_s;
                    frame_valid_d = 1'b1;
                    if (err_s && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
            endcase
        end else begin
            // No valid bit: everything holds, gaps are transparent.
            state_d = state_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            acc_q         <= 1'b0;
            shift_q       <= '0;
            data_out_q    <= '0;
            frame_valid_q <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
            err_cnt_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            frame_valid_q <= frame_valid_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            busy_q        <= busy_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign bus.DATA_OUT    = data_out_q;
    assign bus.FRAME_VALID = frame_valid_q;
    assign bus.PARITY_ERR  = parity_err_q;
    assign bus.FRAMING_ERR = framing_err_q;
    assign bus.BUSY        = busy_q;
    assign bus.ERR_CNT     = err_cnt_q;

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Receive-side partner of the team's XOR parity generator gates.
- Deserialises a bit-serial frame: DATA_W data bits, LSB first, then one parity bit.
- Checks parity, presents the parallel word and reports parity and framing errors.
- Sits between a serial link front-end and the parallel datapath.

Parameters:
DATA_W, 8, number of data bits per frame (legal range 1..32)
ODD, 0, 0 = even parity expected, 1 = odd parity expected

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
BIT_VALID  input  1  BIT_IN/SOF are sampled this cycle
BIT_IN  input  1  serial bit
SOF  input  1  qualifies the current BIT_VALID bit as data bit 0 of a new frame
DATA_OUT  output  DATA_W  last received data word, held until the next frame completes
FRAME_VALID  output  1  one-cycle pulse: a frame has completed
PARITY_ERR  output  1  parity result of the last frame, valid with FRAME_VALID and held after it
FRAMING_ERR  output  1  one-cycle pulse: the current frame was aborted by SOF
BUSY  output  1  high while in DATA or PARITY state
ERR_CNT  output  8  saturating count of parity errors

Behaviour:
- Interface: one clock CLK; reset RST_N is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; bit counter 0; parity accumulator 0; shift register 0.
- All inputs are ignored when BIT_VALID=0. Gaps of any length are allowed between bits with no effect on state.
- IDLE state:
  - BIT_VALID & SOF: shift in BIT_IN as bit 0, acc = BIT_IN, count = 1, go to DATA.
  - If DATA_W=1, go directly to PARITY.
  - BIT_VALID without SOF: discard the bit, stay in IDLE, no flag raised.
- DATA state:
  - BIT_VALID & !SOF: shift BIT_IN into position count (LSB first), acc ^= BIT_IN, count++.
  - When count reaches DATA_W, go to PARITY.
- PARITY state, on BIT_VALID & !SOF:
  - err = acc ^ BIT_IN ^ ODD.
  - Next cycle: DATA_OUT <= shift register, PARITY_ERR <= err, FRAME_VALID = 1 for exactly one cycle.
  - Same cycle as that pulse: ERR_CNT increments if err and ERR_CNT < 255.
  - Return to IDLE.
  - Latency: FRAME_VALID rises on the clock edge after the parity bit is sampled.
- SOF in DATA or PARITY state (with BIT_VALID):
  - Abort the partial frame; FRAMING_ERR pulses one cycle on the next edge.
  - The same bit starts a new frame (count = 1, acc = BIT_IN).
  - DATA_OUT, PARITY_ERR and ERR_CNT are unchanged.
- Back-to-back frames: SOF may arrive the cycle after the parity bit. The checker is in IDLE by then, so there is no gap requirement.
- ERR_CNT saturates at 255 and never wraps. It clears only on reset.
- BUSY = (state != IDLE), registered.
- Reset asserted mid-frame: immediate return to the reset values. The partial frame is lost and no pulse is generated.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. DATA_W=8, ODD=0: SOF + bits of 0xA5 LSB first, parity bit 0, BIT_VALID continuous -> one cycle after the parity bit: FRAME_VALID=1 for one cycle, DATA_OUT=0xA5, PARITY_ERR=0, ERR_CNT=0.
2. Same frame 0xA5 with parity bit 1 -> PARITY_ERR=1, ERR_CNT=1, DATA_OUT=0xA5. Follow with 0x01 parity 1 -> PARITY_ERR=0, ERR_CNT stays 1.
3. Frame 0x3C with parity 0, with 0-3 idle cycles of BIT_VALID=0 randomly inserted between bits -> same result as a continuous frame, DATA_OUT=0x3C. BUSY stays high from the first bit until the parity bit is accepted.
4. SOF after 5 data bits, then a full frame 0x81 parity 0 -> FRAMING_ERR pulses once one cycle after that SOF. Next FRAME_VALID shows DATA_OUT=0x81, PARITY_ERR=0. No FRAME_VALID for the aborted frame.
5. Deassert RST_N asynchronously after 4 data bits, release, send 0x7E parity 0 -> no pulse during reset, outputs 0, then DATA_OUT=0x7E with FRAME_VALID.
6. 260 back-to-back bad-parity frames, ODD=1 build with 0x00 parity 0 -> ERR_CNT reaches 255 and holds. PARITY_ERR=1 on each frame.
